vol_avg_sampler: RTL and testbench

Sequencer and filter placed directly in front of the ADC081C021/DAC5571 I2C transaction block. It issues one `gs_trig` pulse per sample, either on a periodic tick or on a manual key pulse. It then waits for `gs_done` with a timeout and captures `vol`. Each captured sample feeds a 2^AVG_LOG2-deep moving average, and the block presents the rounded mean plus a one-cycle valid strobe to downstream display or logic.

---
 rtl/vol_avg_pkg.sv | 20 ++
 rtl/vol_ring_avg.sv | 69 ++++++
 rtl/vol_avg_sampler.sv | 120 ++++++++++++
 tb/tb_vol_avg_sampler.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vol_avg_pkg.sv
// rtl/vol_avg_pkg.sv - shared types and constant helpers for the volume sampler
package vol_avg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT,
    ST_UPDATE
  } state_t;

  // Number of clock cycles spanning the given number of milliseconds.
  function automatic int ms_cycles(input int freq, input int ms);
    return (freq / 1000) * ms;
  endfunction

  function automatic int sum_width(input int avg_log2);
    return 8 + avg_log2;
  endfunction

endpackage

// File: rtl/vol_ring_avg.sv
// rtl/vol_ring_avg.sv - moving-average ring buffer with rounded, saturated mean
module vol_ring_avg
  import vol_avg_pkg::*;
#(
  parameter int AVG_LOG2 = 3
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] sample,
  output logic [7:0] avg,
  output logic       avg_valid
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = sum_width(AVG_LOG2);
  localparam int WP_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int FILL_W = AVG_LOG2 + 1;

  localparam logic [SUM_W:0]    RND       = (SUM_W + 1)'(DEPTH / 2);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  localparam logic [WP_W-1:0]   WP_LAST   = WP_W'(DEPTH - 1);

  logic [7:0]        ring_mem [DEPTH];
  logic [WP_W-1:0]   wp;
  logic [FILL_W-1:0] fill;
  logic [SUM_W-1:0]  sum;

  logic [SUM_W-1:0]  sum_next;
  logic [FILL_W-1:0] fill_next;
  logic [WP_W-1:0]   wp_next;
  logic [SUM_W:0]    rounded;
  logic [7:0]        avg_next;

  // The mean is derived from the post-update sum so it lands in the same edge as the write.
  always_comb begin
    sum_next  = sum - SUM_W'(ring_mem[wp]) + SUM_W'(sample);
    fill_next = (fill == FILL_FULL) ? fill : fill + 1'b1;
    wp_next   = (wp == WP_LAST) ? '0 : wp + 1'b1;
    rounded   = ({1'b0, sum_next} + RND) >> AVG_LOG2;
    avg_next  = (rounded > (SUM_W + 1)'(255)) ? 8'hFF : rounded[7:0];
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      sum       <= '0;
      wp        <= '0;
      fill      <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ring_mem[i] <= '0;
      end
    end else begin
      avg_valid <= 1'b0;
      if (wr) begin
        ring_mem[wp] <= sample;
        sum          <= sum_next;
        wp           <= wp_next;
        fill         <= fill_next;
        if (fill_next == FILL_FULL) begin
          avg       <= avg_next;
          avg_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vol_avg_sampler.sv
// rtl/vol_avg_sampler.sv - trigger sequencer and averaging front end for the I2C ADC block
module vol_avg_sampler
  import vol_avg_pkg::*;
#(
  parameter int SCLK_FREQ        = 50_000_000,
  parameter int SAMPLE_PERIOD_MS = 10,
  parameter int TIMEOUT_MS       = 5,
  parameter int AVG_LOG2         = 3
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       en,
  input  logic       man_trig,
  output logic       gs_trig,
  input  logic       gs_done,
  input  logic [7:0] vol_in,
  output logic [7:0] avg_out,
  output logic       avg_valid,
  output logic [7:0] last_vol,
  output logic       busy,
  output logic       err_timeout
);

  localparam int PERIOD_CYC = ms_cycles(SCLK_FREQ, SAMPLE_PERIOD_MS);
  localparam int TO_CYC     = ms_cycles(SCLK_FREQ, TIMEOUT_MS);
  localparam int PER_W      = $clog2(PERIOD_CYC + 1);
  localparam int TO_W       = $clog2(TO_CYC + 1);

  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TO_CYC - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);

  state_t           state;
  logic [PER_W-1:0] per_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             pending;
  logic [7:0]       sample;
  logic             tick;
  logic             req;
  logic             wr;

  assign tick = en && (per_cnt == PER_LAST);
  assign req  = tick || man_trig;
  assign wr   = (state == ST_UPDATE);

  always_ff @(posedge sclk) begin
    if (rst || !en || tick) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  // Timeout counts down from TRIG so err_timeout lands TIMEOUT_MS after gs_trig.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pending     <= 1'b0;
      gs_trig     <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      to_cnt      <= '0;
      sample      <= '0;
      last_vol    <= '0;
    end else begin
      gs_trig     <= 1'b0;
      err_timeout <= 1'b0;
      if (req) begin
        pending <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (pending || req) begin
            state   <= ST_TRIG;
            gs_trig <= 1'b1;
            busy    <= 1'b1;
            pending <= 1'b0;
          end
        end
        ST_TRIG: begin
          to_cnt <= TO_LOAD;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (gs_done) begin
            sample   <= vol_in;
            last_vol <= vol_in;
            state    <= ST_UPDATE;
          end else if (to_cnt <= TO_ONE) begin
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
            busy        <= 1'b0;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
        end
        ST_UPDATE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  vol_ring_avg #(
    .AVG_LOG2(AVG_LOG2)
  ) u_ring (
    .sclk     (sclk),
    .rst      (rst),
    .wr       (wr),
    .sample   (sample),
    .avg      (avg_out),
    .avg_valid(avg_valid)
  );

endmodule

// File: tb/tb_vol_avg_sampler.sv
// tb/tb_vol_avg_sampler.sv - directed self-checking bench for vol_avg_sampler
module tb_vol_avg_sampler;

  logic       sclk = 1'b0;
  logic       rst;
  logic       en;
  logic       man_trig;
  logic       gs_done;
  logic [7:0] vol_in;
  logic       gs_trig;
  logic [7:0] avg_out;
  logic       avg_valid;
  logic [7:0] last_vol;
  logic       busy;
  logic       err_timeout;

  int cyc = 0;
  int trig_cnt = 0;
  int valid_cnt = 0;
  int checks = 0;
  int failures = 0;

  vol_avg_sampler #(
    .SCLK_FREQ       (1_000_000),
    .SAMPLE_PERIOD_MS(1),
    .TIMEOUT_MS      (1),
    .AVG_LOG2        (2)
  ) dut (
    .sclk       (sclk),
    .rst        (rst),
    .en         (en),
    .man_trig   (man_trig),
    .gs_trig    (gs_trig),
    .gs_done    (gs_done),
    .vol_in     (vol_in),
    .avg_out    (avg_out),
    .avg_valid  (avg_valid),
    .last_vol   (last_vol),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  always #5 sclk = ~sclk;

  always @(posedge sclk) cyc <= cyc + 1;

  always @(negedge sclk) begin
    if (gs_trig) trig_cnt++;
    if (avg_valid) valid_cnt++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic sample_once(input logic [7:0] v);
    man_trig = 1'b1;
    step();
    man_trig = 1'b0;
    check("trig_latency", int'(gs_trig), 1);
    step(3);
    gs_done = 1'b1;
    vol_in  = v;
    step();
    gs_done = 1'b0;
    check("last_vol", int'(last_vol), int'(v));
    step();
  endtask

  task automatic wait_trig(input int limit, output bit found, output int at);
    found = 1'b0;
    at    = 0;
    for (int i = 0; i < limit && !found; i++) begin
      step();
      if (gs_trig) begin
        found = 1'b1;
        at    = cyc;
      end
    end
  endtask

  logic [7:0] vals      [9] = '{8'd10, 8'd20, 8'd30, 8'd41, 8'd90, 8'd255, 8'd255, 8'd255, 8'd255};
  int         exp_valid [9] = '{0, 0, 0, 1, 1, 1, 1, 1, 1};
  int         exp_avg   [9] = '{0, 0, 0, 25, 45, 104, 160, 214, 255};

  initial begin
    bit found;
    int t0, e, v0, base, s_en, tp;
    int tt [4];

    rst = 1'b1; en = 1'b0; man_trig = 1'b0; gs_done = 1'b0; vol_in = 8'd0;
    step(3);
    rst = 1'b0;
    step();
    check("rst_avg_out", int'(avg_out), 0);
    check("rst_avg_valid", int'(avg_valid), 0);
    check("rst_last_vol", int'(last_vol), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_gs_trig", int'(gs_trig), 0);
    check("rst_err", int'(err_timeout), 0);

    // window fill, moving update, saturation
    for (int k = 0; k < 9; k++) begin
      sample_once(vals[k]);
      check($sformatf("valid_s%0d", k), int'(avg_valid), exp_valid[k]);
      check($sformatf("avg_s%0d", k), int'(avg_out), exp_avg[k]);
    end

    // timeout with gs_done withheld
    man_trig = 1'b1;
    step();
    man_trig = 1'b0;
    t0 = cyc;
    v0 = valid_cnt;
    found = 1'b0;
    for (int i = 0; i < 1100 && !found; i++) begin
      step();
      if (err_timeout) found = 1'b1;
    end
    e = cyc;
    check("to_seen", int'(found), 1);
    check("to_latency_in_range", int'((e - t0) >= 999 && (e - t0) <= 1001), 1);
    step();
    check("to_pulse_width", int'(err_timeout), 0);
    check("to_busy", int'(busy), 0);
    check("to_no_valid", valid_cnt - v0, 0);
    check("to_avg_kept", int'(avg_out), 255);
    sample_once(8'd3);
    check("post_to_valid", int'(avg_valid), 1);
    check("post_to_avg", int'(avg_out), 192);

    // periodic tick
    base = trig_cnt;
    en   = 1'b1;
    s_en = cyc;
    vol_in = 8'd100;
    for (int k = 0; k < 4; k++) begin
      wait_trig(1100, found, tt[k]);
      check($sformatf("tick_trig%0d_seen", k), int'(found), 1);
      step(50);
      gs_done = 1'b1;
      step();
      gs_done = 1'b0;
    end
    check("tick_first", tt[0] - s_en, 1000);
    for (int k = 1; k < 4; k++) begin
      check($sformatf("tick_interval%0d", k), tt[k] - tt[k-1], 1000);
    end
    check("tick_trig_count", trig_cnt - base, 4);

    // request collapsing: man_trig coincident with tick, then repeats during WAIT
    tp = tt[3];
    step(tp + 999 - cyc);
    base = trig_cnt;
    man_trig = 1'b1;
    step();
    man_trig = 1'b0;
    check("coll_trig1", int'(gs_trig), 1);
    step(2);
    for (int k = 0; k < 3; k++) begin
      man_trig = 1'b1;
      step();
      man_trig = 1'b0;
      step();
    end
    gs_done = 1'b1;
    step();
    gs_done = 1'b0;
    wait_trig(20, found, e);
    check("coll_trig2_seen", int'(found), 1);
    step(3);
    gs_done = 1'b1;
    step();
    gs_done = 1'b0;
    en = 1'b0;
    step(30);
    check("coll_trig_count", trig_cnt - base, 2);
    check("coll_busy", int'(busy), 0);

    // reset in the middle of WAIT
    man_trig = 1'b1;
    step();
    man_trig = 1'b0;
    step(3);
    check("mid_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    step();
    check("mid_rst_busy", int'(busy), 0);
    step(2);
    rst = 1'b0;
    check("mid_rst_avg_out", int'(avg_out), 0);
    check("mid_rst_last_vol", int'(last_vol), 0);
    check("mid_rst_gs_trig", int'(gs_trig), 0);
    v0 = valid_cnt;
    base = trig_cnt;
    step();
    gs_done = 1'b1;
    vol_in  = 8'd77;
    step();
    gs_done = 1'b0;
    step(5);
    check("mid_rst_late_done_valid", valid_cnt - v0, 0);
    check("mid_rst_late_done_vol", int'(last_vol), 0);
    check("mid_rst_no_trig", trig_cnt - base, 0);
    sample_once(8'd50);
    check("mid_rst_fill_cleared", int'(avg_valid), 0);
    check("mid_rst_avg_hold", int'(avg_out), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
